// File: rtl/tlb_cam_if.sv
// tlb_cam_if - request/response bundle for the tlb_cam content-addressable TLB.
//
// Signals:
//   wren/wrauto/wraddress/wrpattern : entry write (explicit or victim-selected)
//   inval/flush                     : single-entry and whole-array invalidate
//   srch/pattern                    : search request and key
//   mvalid/mfound/maddress/mmulti   : registered search result
//   victim                          : entry the next automatic write will use
// Modports: master drives requests, slave is the CAM itself.
interface tlb_cam_if #(
    parameter int WIDTH = 20,
    parameter int AW    = 3
);
    logic             wren;
    logic             wrauto;
    logic [AW-1:0]    wraddress;
    logic [WIDTH-1:0] wrpattern;
    logic             inval;
    logic             flush;
    logic             srch;
    logic [WIDTH-1:0] pattern;
    logic             mvalid;
    logic             mfound;
    logic [AW-1:0]    maddress;
    logic             mmulti;
    logic [AW-1:0]    victim;

    modport master (
        output wren, wrauto, wraddress, wrpattern, inval, flush, srch, pattern,
        input  mvalid, mfound, maddress, mmulti, victim
    );

    modport slave (
        input  wren, wrauto, wraddress, wrpattern, inval, flush, srch, pattern,
        output mvalid, mfound, maddress, mmulti, victim
    );
endinterface

// File: rtl/tlb_cam.sv
// tlb_cam - DEPTH-entry fully associative tag store with one-cycle search.
//
// Ports:
//   clk   : sole clock, rising edge
//   clrn  : asynchronous active-low reset (valid bits, round-robin pointer, results)
//   bus   : tlb_cam_if.slave - write/invalidate/flush/search requests, registered
//           search result and the combinational victim index
//
// A search compares against the array as it stood before the edge, so a
// write/invalidate/flush in the same cycle is only seen by later searches.
module tlb_cam #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic      clk,
    input  logic      clrn,
    tlb_cam_if.slave  bus
);

    logic [WIDTH-1:0] tag_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [AW-1:0]    rrptr_r;

    logic             mvalid_r;
    logic             mfound_r;
    logic [AW-1:0]    maddress_r;
    logic             mmulti_r;

    logic [DEPTH-1:0] match_s;
    logic [AW-1:0]    enc_s;
    logic [AW-1:0]    free_s;
    logic [AW-1:0]    victim_s;
    logic [AW-1:0]    wr_idx_s;
    logic             found_s;
    logic             multi_s;
    logic             all_valid_s;
    logic             addr_ok_s;
    logic             wr_ok_s;
    logic             inv_ok_s;

    // Per-entry compare: an invalid entry never matches, whatever its stale tag holds.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = valid_r[i] && (tag_r[i] == bus.pattern);
        end
    end

    // Lowest-index matching entry (scan downward so the lowest hit is the last assignment).
    always_comb begin
        enc_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            enc_s = match_s[i] ? AW'(i) : enc_s;
        end
    end

    // Lowest-index free entry, falling back to the round-robin pointer when the array is full.
    always_comb begin
        free_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_s = (!valid_r[i]) ? AW'(i) : free_s;
        end
        victim_s = all_valid_s ? rrptr_r : free_s;
    end

    assign found_s     = |match_s;
    // Clearing the lowest set bit leaves something only if two or more entries hit.
    assign multi_s     = |(match_s & (match_s - DEPTH'(1)));
    assign all_valid_s = &valid_r;

    // Explicit addresses beyond the last entry are dropped rather than aliased.
    assign addr_ok_s = ({1'b0, bus.wraddress} < (AW + 1)'(DEPTH));
    assign wr_idx_s  = bus.wrauto ? victim_s : bus.wraddress;
    assign wr_ok_s   = bus.wren  && !bus.flush && (bus.wrauto || addr_ok_s);
    assign inv_ok_s  = bus.inval && !bus.flush && addr_ok_s;

    // Valid bits: flush dominates; on a shared entry the write beats the invalidate.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_r <= '0;
        end else if (bus.flush) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok_s && (wr_idx_s == AW'(i))) begin
                    valid_r[i] <= 1'b1;
                end else if (inv_ok_s && (bus.wraddress == AW'(i))) begin
                    valid_r[i] <= 1'b0;
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    // Round-robin pointer only moves when an automatic write has to evict a live entry.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rrptr_r <= '0;
        end else if (wr_ok_s && bus.wrauto && all_valid_s) begin
            rrptr_r <= (rrptr_r == AW'(DEPTH - 1)) ? '0 : rrptr_r + AW'(1);
        end else begin
            rrptr_r <= rrptr_r;
        end
    end

    // Tag storage carries no reset; its content is meaningless until the entry is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok_s && (wr_idx_s == AW'(i))) begin
                tag_r[i] <= bus.wrpattern;
            end
        end
    end

    // Search result register: pulse mvalid, hold the result fields between searches.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mvalid_r   <= 1'b0;
            mfound_r   <= 1'b0;
            maddress_r <= '0;
            mmulti_r   <= 1'b0;
        end else begin
            mvalid_r <= bus.srch;
            if (bus.srch) begin
                mfound_r   <= found_s;
                maddress_r <= enc_s;
                mmulti_r   <= multi_s;
            end
        end
    end

    assign bus.mvalid   = mvalid_r;
    assign bus.mfound   = mfound_r;
    assign bus.maddress = maddress_r;
    assign bus.mmulti   = mmulti_r;
    assign bus.victim   = victim_s;

endmodule
